// File: rtl/wb_arbiter_nx1_if.sv
// Wishbone bus bundle carrying N request lanes; N=1 for the shared slave side,
// N=N_MASTERS for the master side, with lane i at slice [i*width +: width].
interface wb_arbiter_nx1_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int N  = 1
) ();
  logic [N*AW-1:0]     adr;
  logic [N*DW-1:0]     dat_w;
  logic [N*(DW/8)-1:0] sel;
  logic [N*3-1:0]      cti;
  logic [N*2-1:0]      bte;
  logic [N-1:0]        cyc;
  logic [N-1:0]        stb;
  logic [N-1:0]        we;
  logic [DW-1:0]       dat_r;
  logic [N-1:0]        ack;
  logic [N-1:0]        err;

  modport master (output adr, dat_w, sel, cti, bte, cyc, stb, we,
                  input  dat_r, ack, err);
  modport slave  (input  adr, dat_w, sel, cti, bte, cyc, stb, we,
                  output dat_r, ack, err);
endinterface

// File: rtl/wb_arbiter_nx1.sv
// Round-robin N:1 Wishbone arbiter; grant held for a whole CYC burst.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that aborts a hung slave access with ERR.
module wb_arbiter_nx1 #(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int N_MASTERS      = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_arbiter_nx1_if.slave      m,
  wb_arbiter_nx1_if.master     s,
  output logic [N_MASTERS-1:0] gnt
);
  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = WB_DATA_WIDTH;
  localparam int SW = WB_DATA_WIDTH / 8;
  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  if (N_MASTERS < 2 || N_MASTERS > 8) begin : g_bad_n
    $error("wb_arbiter_nx1: N_MASTERS must be 2..8");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_to
    $error("wb_arbiter_nx1: TIMEOUT_CYCLES must be 2..65536");
  end

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUSY} state_t;
`endif

  state_t                state_reg, state_next;
  logic [N_MASTERS-1:0]  gnt_reg, gnt_next;
  logic [IW-1:0]         gidx_reg, gidx_next;
  logic [IW-1:0]         prio_reg, prio_next;
  logic [IW-1:0]         winner;
  int                    idx;

  logic [AW-1:0] adr_arr   [N_MASTERS];
  logic [DW-1:0] dat_w_arr [N_MASTERS];
  logic [SW-1:0] sel_arr   [N_MASTERS];
  logic [2:0]    cti_arr   [N_MASTERS];
  logic [1:0]    bte_arr   [N_MASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_lane
      assign adr_arr[gi]   = m.adr[gi*AW +: AW];
      assign dat_w_arr[gi] = m.dat_w[gi*DW +: DW];
      assign sel_arr[gi]   = m.sel[gi*SW +: SW];
      assign cti_arr[gi]   = m.cti[gi*3 +: 3];
      assign bte_arr[gi]   = m.bte[gi*2 +: 2];
    end
  endgenerate

  // First requester at or after the priority pointer, wrapping N-1 -> 0.
  always_comb begin
    winner = prio_reg;
    idx    = 0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      idx = int'(prio_reg) + k;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      if (m.cyc[idx]) winner = IW'(idx);
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_reg;
  logic        timeout;

  // Granted stb is used rather than s.stb so the abort does not feed back on itself.
  assign timeout = (state_reg == BUSY) && m.stb[gidx_reg] && !s.ack[0] && !s.err[0] &&
                   (cnt_reg == TO_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (s.ack[0] || s.err[0] || !((state_reg == BUSY) && s.stb[0])) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      gidx_reg  <= '0;
      prio_reg  <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      gidx_reg  <= gidx_next;
      prio_reg  <= prio_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    gidx_next  = gidx_reg;
    prio_next  = prio_reg;
    s.adr      = '0;
    s.dat_w    = '0;
    s.sel      = '0;
    s.cti      = '0;
    s.bte      = '0;
    s.cyc      = '0;
    s.stb      = '0;
    s.we       = '0;
    m.dat_r    = '0;
    m.ack      = '0;
    m.err      = '0;

    case (state_reg)
      IDLE: begin
        if (|m.cyc) begin
          state_next         = BUSY;
          gnt_next           = '0;
          gnt_next[winner]   = 1'b1;
          gidx_next          = winner;
          prio_next          = (int'(winner) == N_MASTERS - 1) ? '0 : winner + 1'b1;
        end
      end
      BUSY: begin
        s.adr   = adr_arr[gidx_reg];
        s.dat_w = dat_w_arr[gidx_reg];
        s.sel   = sel_arr[gidx_reg];
        s.cti   = cti_arr[gidx_reg];
        s.bte   = bte_arr[gidx_reg];
        s.cyc   = m.cyc[gidx_reg];
        s.stb   = m.stb[gidx_reg];
        s.we    = m.we[gidx_reg];
        m.dat_r = s.dat_r;
        m.ack   = s.ack[0] ? gnt_reg : '0;
        m.err   = s.err[0] ? gnt_reg : '0;
        if (!m.cyc[gidx_reg]) begin
          state_next = IDLE;
          gnt_next   = '0;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (timeout) begin
          s.cyc      = 1'b0;
          s.stb      = 1'b0;
          m.err      = gnt_reg;
          state_next = DRAIN;
        end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      DRAIN: begin
        if (!m.cyc[gidx_reg]) begin
          state_next = IDLE;
          gnt_next   = '0;
        end
      end
`endif
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  assign gnt = gnt_reg;
endmodule
